// File: rtl/flappy_pkg.sv
// Shared types and helpers for the flappy pipe field.
package flappy_pkg;
  localparam int GRID_N = 16;

  typedef logic [GRID_N-1:0][GRID_N-1:0] frame_t;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} scroll_state_t;

  // Pipe column from the LFSR: every row set except a GAP rows tall opening.
  // Out-of-range nibbles fold back to the top so the gap always fits.
  function automatic logic [GRID_N-1:0] pipe_column(input logic [7:0] lfsr_value,
                                                     input int gap_height);
    logic [GRID_N-1:0] col;
    int max_top;
    int gap_top;
    max_top = GRID_N - gap_height;
    gap_top = (int'(lfsr_value[3:0]) <= max_top) ? int'(lfsr_value[3:0])
                                                  : int'(lfsr_value[3:0]) - (max_top + 1);
    for (int r = 0; r < GRID_N; r++)
      col[r] = !((r >= gap_top) && (r < gap_top + gap_height));
    return col;
  endfunction
endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifting left into bit 0.
module lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] value
);
  logic [7:0] seed_safe;
  logic       feedback;

  // An all-zero state would lock up, so a zero seed starts at 1 instead.
  assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;
  assign feedback  = value[7] ^ value[5] ^ value[4] ^ value[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      value <= seed_safe;
    else if (advance)
      value <= {value[6:0], feedback};
  end
endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe field for the 16x16 matrix with pipe-cleared scoring.
// Optional SCROLL_SPEEDUP_EN shortens the step period as the score rises.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int         TICK_DIV     = 25000000,
  parameter int         PIPE_SPACING = 6,
  parameter int         GAP_HEIGHT   = 4,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   isDead,
  output frame_t GrnPixels,
  output logic [7:0] score,
  output logic   scored,
  output logic   running
);
  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;

  scroll_state_t     state;
  logic [TW-1:0]     tick;
  logic [SW-1:0]     spawn;
  logic [7:0]        lfsr;
  logic [31:0]       tick_last;
  logic              tick_wrap;
  logic              step;
  logic [GRID_N-1:0] new_col;
  logic [GRID_N-1:0] col0;
  frame_t            shifted;

`ifdef SCROLL_SPEEDUP_EN
  logic [1:0] speed_shift;
  assign speed_shift = (score[7:3] > 5'd3) ? 2'd3 : score[4:3];
  assign tick_last   = (32'(TICK_DIV) >> speed_shift) - 32'd1;
`else
  assign tick_last = 32'(TICK_DIV - 1);
`endif

  // Wrapping on ">=" also restarts the count when the period shrinks under it.
  assign tick_wrap = (32'(tick) >= tick_last);
  assign step      = (state == RUN) && !isDead && (32'(tick) == tick_last);
  assign new_col   = (spawn == '0) ? pipe_column(lfsr, GAP_HEIGHT) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < GRID_N; gi++) begin : g_rows
      assign col0[gi]    = GrnPixels[gi][0];
      assign shifted[gi] = {new_col[gi], GrnPixels[gi][GRID_N-1:1]};
    end
  endgenerate

  lfsr8 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed   (LFSR_SEED),
    .advance(step),
    .value  (lfsr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      GrnPixels <= '0;
      score     <= 8'd0;
      scored    <= 1'b0;
      running   <= 1'b0;
      tick      <= '0;
      spawn     <= '0;
    end else begin
      scored <= 1'b0;
      case (state)
        IDLE, DEAD: begin
          if (start) begin
            state     <= RUN;
            running   <= 1'b1;
            GrnPixels <= '0;
            score     <= 8'd0;
            tick      <= '0;
            spawn     <= '0;
          end
        end
        RUN: begin
          if (isDead) begin
            state   <= DEAD;
            running <= 1'b0;
          end else begin
            tick <= tick_wrap ? '0 : tick + 1'b1;
            if (step) begin
              GrnPixels <= shifted;
              spawn     <= (spawn == SW'(PIPE_SPACING - 1)) ? '0 : spawn + 1'b1;
              if (|col0) begin
                scored <= 1'b1;
                if (score != 8'hFF)
                  score <= score + 8'd1;
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against a column-queue reference model.
module tb_pipe_scroller;
  import flappy_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int PIPE_SPACING = 3;
  localparam int GAP_HEIGHT   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk;
  logic       reset;
  logic       start;
  logic       isDead;
  frame_t     GrnPixels;
  logic [7:0] score;
  logic       scored;
  logic       running;

  int errors = 0;
  int checks = 0;

  // Reference model: field kept as 16 column masks, oldest (leftmost) first.
  int         m_state;   // 0 idle, 1 run, 2 dead
  logic [15:0] m_cols[16];
  int         m_score;
  bit         m_scored;
  int         m_cycles;  // running cycles since start, excluding frozen ones
  int         m_steps;
  logic [7:0] m_lfsr;

  pipe_scroller #(
    .TICK_DIV    (TICK_DIV),
    .PIPE_SPACING(PIPE_SPACING),
    .GAP_HEIGHT  (GAP_HEIGHT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .isDead   (isDead),
    .GrnPixels(GrnPixels),
    .score    (score),
    .scored   (scored),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pipe(input logic [7:0] l);
    int g;
    logic [15:0] col;
    g = int'(l & 8'h0F);
    if (g > 16 - GAP_HEIGHT) g = g - (16 - GAP_HEIGHT + 1);
    col = 16'hFFFF;
    for (int r = g; r < g + GAP_HEIGHT; r++) col[r] = 1'b0;
    return col;
  endfunction

  function automatic frame_t model_frame();
    frame_t f;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        f[r][c] = m_cols[c][r];
    return f;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_score  = 0;
    m_scored = 0;
    m_cycles = 0;
    m_steps  = 0;
    m_lfsr   = SEED;
    for (int c = 0; c < 16; c++) m_cols[c] = '0;
  endtask

  task automatic model_clock(input logic s, input logic d);
    m_scored = 0;
    if (m_state != 1) begin
      if (s) begin
        m_state  = 1;
        m_score  = 0;
        m_cycles = 0;
        m_steps  = 0;
        for (int c = 0; c < 16; c++) m_cols[c] = '0;
      end
    end else if (d) begin
      m_state = 2;
    end else begin
      if (m_cycles % TICK_DIV == TICK_DIV - 1) begin
        if (m_cols[0] != 0) begin
          m_scored = 1;
          if (m_score < 255) m_score++;
        end
        for (int c = 0; c < 15; c++) m_cols[c] = m_cols[c+1];
        m_cols[15] = (m_steps % PIPE_SPACING == 0) ? model_pipe(m_lfsr) : 16'h0;
        m_steps++;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
      m_cycles++;
    end
  endtask

  task automatic cycle(input logic s, input logic d);
    int prev_state;
    @(negedge clk);
    start  = s;
    isDead = d;
    @(posedge clk);
    prev_state = m_state;
    model_clock(s, d);
    #1;
    check("running", 256'(running), 256'(m_state == 1));
    check("score", 256'(score), 256'(m_score));
    check("scored", 256'(scored), 256'(m_scored));
    check("frame", 256'(GrnPixels), 256'(model_frame()));
    if (m_scored || prev_state != m_state)
      $display("t=%0t state=%0d score=%0d scored=%0d steps=%0d",
               $time, m_state, m_score, m_scored, m_steps);
  endtask

  logic [15:0] col15;
  int waited;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    isDead = 1'b0;
    model_reset();
    #3;
    check("reset_frame", 256'(GrnPixels), 256'(0));
    check("reset_running", 256'(running), 256'(0));
    @(negedge clk);
    reset = 1'b1;

    // Idle: isDead is ignored.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'($urandom_range(0, 1)));

    // Start and first pipe: seed nibble 5 gives clear rows 5..8.
    cycle(1'b1, 1'b0);
    for (int i = 0; i < TICK_DIV; i++) cycle(1'b0, 1'b0);
    for (int r = 0; r < 16; r++) col15[r] = GrnPixels[r][15];
    check("first_pipe_col15", 256'(col15), 256'(16'hFE1F));

    // Scroll until the first pipe scores.
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b0);

    // Death on a step cycle: no shift, then frozen for 20 cycles.
    waited = 0;
    while (!(m_state == 1 && m_cycles % TICK_DIV == TICK_DIV - 1) && waited < 20) begin
      cycle(1'b0, 1'b0);
      waited++;
    end
    check("step_wait", 256'(waited < 20), 256'(1));
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
    cycle(1'b1, 1'b1);

    // Random play with occasional deaths and (re)starts.
    for (int i = 0; i < 1500; i++) begin
      if (m_state == 1)
        cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 149) == 0));
      else
        cycle(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Long uninterrupted run to score saturation.
    if (m_state == 1) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3400; i++) cycle(1'($urandom_range(0, 9) == 0), 1'b0);
    check("score_saturated", 256'(score), 256'(255));

    // Mid-cycle asynchronous reset, then a fresh start reuses the seed.
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("async_frame", 256'(GrnPixels), 256'(0));
    check("async_score", 256'(score), 256'(0));
    check("async_running", 256'(running), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
